// File: rtl/regfile_mp_sb.sv
// Multi-port register file with two write ports, write-to-read bypass, a busy scoreboard
// for multicycle producers and a sequenced clear engine that zeroes every register in turn.
module regfile_mp_sb #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREAD*AW-1:0]   ra,
    output logic [NREAD*XLEN-1:0] rd,
    output logic [NREAD-1:0]      rbusy,
    input  logic                  wen0,
    input  logic [AW-1:0]         wa0,
    input  logic [XLEN-1:0]       wd0,
    input  logic                  wen1,
    input  logic [AW-1:0]         wa1,
    input  logic [XLEN-1:0]       wd1,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_rd,
    input  logic                  clr_req,
    output logic                  clr_busy
);

    localparam int DEPTH = 1 << AW;
    localparam bit ZR    = (ZERO_REG != 0);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [AW-1:0]     cnt_r;
    logic [AW-1:0]     cnt_nxt_s;
    logic [XLEN-1:0]   mem_r [DEPTH];
    logic [DEPTH-1:0]  busy_r;
    logic [DEPTH-1:0]  busy_nxt_s;
    logic              idle_s;
    logic              clr_start_s;
    logic              clr_wr_s;
    logic              we0_s;
    logic              we1_s;
    logic              iss_v_s;

    // Qualified write/issue strobes: nothing is accepted while the clear engine runs,
    // and register 0 is never written or marked busy when hardwired to zero.
    always_comb begin
        idle_s      = (state_r == IDLE);
        clr_start_s = idle_s && clr_req;
        clr_wr_s    = (state_r == CLEAR);
        we0_s       = wen0 && idle_s && !(ZR && (wa0 == {AW{1'b0}}));
        we1_s       = wen1 && idle_s && !(ZR && (wa1 == {AW{1'b0}}));
        iss_v_s     = iss_en && idle_s && !(ZR && (iss_rd == {AW{1'b0}}));
        clr_busy    = clr_wr_s;
    end

    // Clear FSM state and sweep counter register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= {AW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Clear FSM next state; the counter wraps to 0 naturally after the last register.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (clr_req) begin
                    state_nxt_s = CLEAR;
                    cnt_nxt_s   = {AW{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = cnt_r;
                end
            end
            CLEAR: begin
                cnt_nxt_s = cnt_r + {{(AW-1){1'b0}}, 1'b1};
                if (cnt_r == AW'(DEPTH - 1)) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = CLEAR;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {AW{1'b0}};
            end
        endcase
    end

    // Scoreboard next value: a new issue outranks a same-cycle writeback to the same register.
    always_comb begin
        busy_nxt_s = busy_r;
        if (clr_start_s) begin
            busy_nxt_s = {DEPTH{1'b0}};
        end else if (idle_s) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (iss_v_s && (iss_rd == AW'(i))) begin
                    busy_nxt_s[i] = 1'b1;
                end else if ((we0_s && (wa0 == AW'(i))) || (we1_s && (wa1 == AW'(i)))) begin
                    busy_nxt_s[i] = 1'b0;
                end else begin
                    busy_nxt_s[i] = busy_r[i];
                end
            end
        end else begin
            busy_nxt_s = busy_r;
        end
    end

    // Register array and scoreboard storage; port 1 overrides port 0 on an address clash.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {XLEN{1'b0}};
            end
            busy_r <= {DEPTH{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (clr_wr_s && (cnt_r == AW'(i))) begin
                    mem_r[i] <= {XLEN{1'b0}};
                end else if (we1_s && (wa1 == AW'(i))) begin
                    mem_r[i] <= wd1;
                end else if (we0_s && (wa0 == AW'(i))) begin
                    mem_r[i] <= wd0;
                end else begin
                    mem_r[i] <= mem_r[i];
                end
            end
            busy_r <= busy_nxt_s;
        end
    end

    // Combinational read ports with bypass; busy bits come straight from the scoreboard.
    always_comb begin
        rd    = {(NREAD*XLEN){1'b0}};
        rbusy = {NREAD{1'b0}};
        for (int k = 0; k < NREAD; k++) begin
            if (ZR && (ra[k*AW +: AW] == {AW{1'b0}})) begin
                rd[k*XLEN +: XLEN] = {XLEN{1'b0}};
                rbusy[k]           = 1'b0;
            end else begin
                rbusy[k] = busy_r[ra[k*AW +: AW]];
                if (we1_s && (wa1 == ra[k*AW +: AW])) begin
                    rd[k*XLEN +: XLEN] = wd1;
                end else if (we0_s && (wa0 == ra[k*AW +: AW])) begin
                    rd[k*XLEN +: XLEN] = wd0;
                end else begin
                    rd[k*XLEN +: XLEN] = mem_r[ra[k*AW +: AW]];
                end
            end
        end
    end

endmodule
